// File: rtl/board_pkg.sv
// Shared board definitions for the 5x5 flood-fill walk.
// FLOOD_FILL_DIAG_EN selects 8-neighbour connectivity (default: 4-neighbour).
package board_pkg;

  localparam int GRID   = 5;
  localparam int CELLS  = GRID * GRID;
  localparam int RANK_W = 5;

  typedef logic [4:0] cell_idx_t;

  typedef enum logic [2:0] {
    DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT,
    DIR_UL, DIR_UR, DIR_DL, DIR_DR
  } dir_e;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_POP, S_CHECK, S_DONE
  } state_e;

`ifdef FLOOD_FILL_DIAG_EN
  localparam dir_e DIR_LAST = DIR_DR;
`else
  localparam dir_e DIR_LAST = DIR_RIGHT;
`endif

  // Queue pointers wrap 24 -> 0.
  function automatic cell_idx_t ptr_inc(cell_idx_t p);
    return (p == cell_idx_t'(CELLS - 1)) ? '0 : p + 5'd1;
  endfunction

endpackage

// File: rtl/flood_neighbor.sv
// Combinational neighbour lookup: index of the cell one step from cur in dir.
// Diagonal directions exist only when FLOOD_FILL_DIAG_EN is defined.
module flood_neighbor
  import board_pkg::*;
#(
  parameter int GRID = 5
) (
  input  logic [4:0] cur,
  input  logic [2:0] dir,
  output logic [4:0] nb,
  output logic       in_bounds
);

  logic [2:0] row, col;
  logic       top, bot, lft, rgt;

  always_comb begin
    row = 3'(cur / GRID);
    col = 3'(cur % GRID);
    top = (row != 3'd0);
    bot = (row != 3'(GRID - 1));
    lft = (col != 3'd0);
    rgt = (col != 3'(GRID - 1));
  end

  // Index is forced to 0 when off-board so callers never index past the map.
  always_comb begin
    nb        = '0;
    in_bounds = 1'b0;
    case (dir_e'(dir))
      DIR_UP:    if (top) begin in_bounds = 1'b1; nb = cur - 5'(GRID); end
      DIR_DOWN:  if (bot) begin in_bounds = 1'b1; nb = cur + 5'(GRID); end
      DIR_LEFT:  if (lft) begin in_bounds = 1'b1; nb = cur - 5'd1; end
      DIR_RIGHT: if (rgt) begin in_bounds = 1'b1; nb = cur + 5'd1; end
`ifdef FLOOD_FILL_DIAG_EN
      DIR_UL: if (top && lft) begin in_bounds = 1'b1; nb = cur - 5'(GRID + 1); end
      DIR_UR: if (top && rgt) begin in_bounds = 1'b1; nb = cur - 5'(GRID - 1); end
      DIR_DL: if (bot && lft) begin in_bounds = 1'b1; nb = cur + 5'(GRID - 1); end
      DIR_DR: if (bot && rgt) begin in_bounds = 1'b1; nb = cur + 5'(GRID + 1); end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/flood_fill_ctrl.sv
// Breadth-first flood fill over a latched 5x5 trace, producing a visit-rank map and size.
// FLOOD_FILL_DIAG_EN enables 8-neighbour connectivity.
module flood_fill_ctrl
  import board_pkg::*;
#(
  parameter int GRID = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [24:0]  trace,
  input  logic [4:0]   start_cell,
  output logic         busy,
  output logic         done,
  output logic [124:0] order_out,
  output logic [4:0]   count_out
);

  state_e    state_q, state_d;
  dir_e      dir_q, dir_d;
  cell_idx_t cur_q, cur_d;
  cell_idx_t seed_q, seed_d;
  cell_idx_t head_q, head_d;
  cell_idx_t tail_q, tail_d;
  logic [CELLS-1:0]             trace_q, trace_d;
  logic [CELLS-1:0][RANK_W-1:0] order_q, order_d;
  logic [CELLS-1:0][4:0]        fifo_q, fifo_d;
  logic [RANK_W-1:0]            count_q, count_d;

  logic [4:0] nb_idx;
  logic       nb_in;
  logic       seed_ok, nb_new;

  flood_neighbor #(.GRID(GRID)) u_nb (
    .cur       (cur_q),
    .dir       (dir_q),
    .nb        (nb_idx),
    .in_bounds (nb_in)
  );

  always_comb begin
    seed_ok = (seed_q < cell_idx_t'(CELLS)) && trace_q[seed_q];
    nb_new  = nb_in && trace_q[nb_idx] && (order_q[nb_idx] == '0);
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cur_d   = cur_q;
    seed_d  = seed_q;
    head_d  = head_q;
    tail_d  = tail_q;
    trace_d = trace_q;
    order_d = order_q;
    fifo_d  = fifo_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: if (start) begin
        trace_d = trace;
        seed_d  = start_cell;
        order_d = '0;
        fifo_d  = '0;
        count_d = '0;
        head_d  = '0;
        tail_d  = '0;
        dir_d   = DIR_UP;
        state_d = S_INIT;
      end
      S_INIT: begin
        if (seed_ok) begin
          order_d[seed_q] = RANK_W'(1);
          count_d         = RANK_W'(1);
          fifo_d[tail_q]  = seed_q;
          tail_d          = ptr_inc(tail_q);
        end
        state_d = S_POP;
      end
      S_POP: begin
        if (head_q == tail_q) begin
          state_d = S_DONE;
        end else begin
          cur_d   = fifo_q[head_q];
          head_d  = ptr_inc(head_q);
          dir_d   = DIR_UP;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (nb_new) begin
          order_d[nb_idx] = count_q + RANK_W'(1);
          count_d         = count_q + RANK_W'(1);
          fifo_d[tail_q]  = nb_idx;
          tail_d          = ptr_inc(tail_q);
        end
        if (dir_q == DIR_LAST) state_d = S_POP;
        else                   dir_d   = dir_e'(dir_q + 3'd1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_UP;
      cur_q   <= '0;
      seed_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      trace_q <= '0;
      order_q <= '0;
      fifo_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cur_q   <= cur_d;
      seed_q  <= seed_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      trace_q <= trace_d;
      order_q <= order_d;
      fifo_q  <= fifo_d;
      count_q <= count_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign order_out = order_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_flood_fill_ctrl.sv
// Randomised and directed bench for flood_fill_ctrl against a queue-based BFS model.
module tb_flood_fill_ctrl;

`ifdef FLOOD_FILL_DIAG_EN
  localparam int NDIR = 8;
`else
  localparam int NDIR = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [24:0]  trace = '0;
  logic [4:0]   start_cell = '0;
  logic         busy, done;
  logic [124:0] order_out;
  logic [4:0]   count_out;

  int checks = 0;
  int failures = 0;

  flood_fill_ctrl #(.GRID(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .trace      (trace),
    .start_cell (start_cell),
    .busy       (busy),
    .done       (done),
    .order_out  (order_out),
    .count_out  (count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference BFS straight from the rules: row/col steps, visit order up/down/left/right(/diagonals).
  function automatic void model(input logic [24:0] tr, input int seed,
                                output logic [124:0] ord, output int cnt);
    int q[$];
    int dr[8] = '{-1, 1, 0, 0, -1, -1, 1, 1};
    int dc[8] = '{ 0, 0, -1, 1, -1, 1, -1, 1};
    ord = '0;
    cnt = 0;
    if (seed < 25 && tr[seed]) begin
      cnt = 1;
      ord[seed*5 +: 5] = 5'd1;
      q.push_back(seed);
    end
    while (q.size() > 0) begin
      int c;
      c = q.pop_front();
      for (int d = 0; d < NDIR; d++) begin
        int nr, nc, n;
        nr = c / 5 + dr[d];
        nc = c % 5 + dc[d];
        if (nr >= 0 && nr < 5 && nc >= 0 && nc < 5) begin
          n = nr * 5 + nc;
          if (tr[n] && ord[n*5 +: 5] == 5'd0) begin
            cnt++;
            ord[n*5 +: 5] = 5'(cnt);
            q.push_back(n);
          end
        end
      end
    end
  endfunction

  // Present start for exactly one edge (edge k), then release it.
  task automatic launch(input logic [24:0] tr, input logic [4:0] sc, input string tag);
    @(negedge clk);
    trace = tr;
    start_cell = sc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy_after_accept"}, 128'(busy), 128'd1);
  endtask

  // Wait for done from edge k, then check latency, map and count against the model.
  task automatic finish(input logic [24:0] tr, input logic [4:0] sc, input string tag,
                        input bit poke);
    logic [124:0] exp_ord;
    int exp_cnt, lat;
    model(tr, int'(sc), exp_ord, exp_cnt);
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (poke && lat == 3) begin
        start = 1'b1;
        trace = ~tr;
        start_cell = sc + 5'd1;
      end
      if (poke && lat == 5) start = 1'b0;
    end
    chk({tag, ".latency"}, 128'(lat), 128'(2 + (NDIR + 1) * exp_cnt));
    chk({tag, ".count"}, 128'(count_out), 128'(exp_cnt));
    chk({tag, ".order"}, 128'(order_out), 128'(exp_ord));
    chk({tag, ".busy_in_done"}, 128'(busy), 128'd1);
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 128'(done), 128'd0);
    chk({tag, ".busy_clear"}, 128'(busy), 128'd0);
  endtask

  function automatic logic [4:0] rank(input logic [124:0] m, input int c);
    return m[c*5 +: 5];
  endfunction

  initial begin
    logic [24:0] tr;
    logic [4:0]  sc;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 128'(busy), 128'd0);
    chk("reset.done", 128'(done), 128'd0);
    chk("reset.order", 128'(order_out), 128'd0);
    chk("reset.count", 128'(count_out), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full board from the corner.
    launch(25'h1FFFFFF, 5'd0, "full");
    finish(25'h1FFFFFF, 5'd0, "full", 1'b0);
    chk("full.r5", 128'(rank(order_out, 5)), 128'd2);
    chk("full.r1", 128'(rank(order_out, 1)), 128'd3);
    chk("full.r10", 128'(rank(order_out, 10)), 128'd4);
    chk("full.cnt25", 128'(count_out), 128'd25);
    idle_after("full");

    launch(25'h0, 5'd12, "empty");
    finish(25'h0, 5'd12, "empty", 1'b0);
    idle_after("empty");

    launch(25'h7, 5'd1, "row3");
    finish(25'h7, 5'd1, "row3", 1'b0);
    chk("row3.r1", 128'(rank(order_out, 1)), 128'd1);
    chk("row3.r0", 128'(rank(order_out, 0)), 128'd2);
    chk("row3.r2", 128'(rank(order_out, 2)), 128'd3);
    idle_after("row3");

    launch(25'h30, 5'd4, "wrap");
    finish(25'h30, 5'd4, "wrap", 1'b0);
    chk("wrap.cnt", 128'(count_out), 128'd1);
    chk("wrap.r5", 128'(rank(order_out, 5)), 128'd0);
    idle_after("wrap");

    launch(25'h41, 5'd0, "diag");
    finish(25'h41, 5'd0, "diag", 1'b0);
`ifdef FLOOD_FILL_DIAG_EN
    chk("diag.cnt", 128'(count_out), 128'd2);
    chk("diag.r6", 128'(rank(order_out, 6)), 128'd2);
`else
    chk("diag.cnt", 128'(count_out), 128'd1);
`endif
    idle_after("diag");

    launch(25'h1FFFFFF, 5'd27, "badseed");
    finish(25'h1FFFFFF, 5'd27, "badseed", 1'b0);
    idle_after("badseed");

    // Extra start while busy must not disturb the run.
    launch(25'h0F3A5C7, 5'd2, "poke");
    finish(25'h0F3A5C7, 5'd2, "poke", 1'b1);
    idle_after("poke");

    // Start during done is ignored; the next cycle's start is taken.
    launch(25'h00000E0, 5'd6, "b2b1");
    finish(25'h00000E0, 5'd6, "b2b1", 1'b0);
    trace = 25'h0108421;
    start_cell = 5'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b.ignored_in_done", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b.accepted", 128'(busy), 128'd1);
    finish(25'h0108421, 5'd0, "b2b2", 1'b0);
    idle_after("b2b2");

    // Reset in the middle of a CHECK sequence.
    launch(25'h1FFFFFF, 5'd12, "rst");
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.busy", 128'(busy), 128'd0);
    chk("rst.done", 128'(done), 128'd0);
    chk("rst.order", 128'(order_out), 128'd0);
    chk("rst.count", 128'(count_out), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(25'h1FFFFFF, 5'd12, "post_rst");
    finish(25'h1FFFFFF, 5'd12, "post_rst", 1'b0);
    idle_after("post_rst");

    for (int i = 0; i < 24; i++) begin
      tr = 25'($urandom) | 25'($urandom);
      sc = 5'($urandom_range(0, 26));
      launch(tr, sc, $sformatf("rnd%0d", i));
      finish(tr, sc, $sformatf("rnd%0d", i), 1'b0);
      idle_after($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
